lap_stopwatch_controller: RTL and testbench
===========================================

# lap_stopwatch_controller

Parametrised stopwatch controller: the next generation of the start/stop/reset controller. Raw push-button inputs are synchronised and debounced on-chip, so the wait-for-release states are no longer needed. The block owns the elapsed-time counter with a tick prescaler and wrap/saturate mode, and captures lap times into a small first-word-fall-through (FWFT) FIFO that a display or readout block drains with a valid/ready handshake.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed to accept a button level change (≥2).
- TICK_DIV, 1: clocks per count increment while running (≥1).
- COUNT_WIDTH, 16: width of the elapsed counter and lap entries.
- SATURATE, 0: 0 = count wraps at all-ones to 0; 1 = count holds at all-ones.
- LAP_DEPTH, 4: lap FIFO entries (power of 2, ≥2).
- clk  input  1  single clock, rising edge.
- resetButton  input  1  asynchronous, active-high reset; clears all state.
- startStopButton  input  1  raw, asynchronous button.
- lapButton  input  1  raw, asynchronous button.
- reset  output  1  high while in IDLE (downstream clear).
- cnt  output  1  high while in RUN.
- count  output  COUNT_WIDTH  elapsed count.
- wrapped  output  1  sticky; set on wrap (SATURATE=0) or on reaching all-ones (SATURATE=1).
- lapData  output  COUNT_WIDTH  FIFO head; 0 when empty.
- lapValid  output  1  FIFO non-empty.
- lapReady  input  1  consumer accepts the head when lapValid && lapReady.
- lapFull  output  1  FIFO holds LAP_DEPTH entries.
- lapOverflow  output  1  sticky; a lap was dropped because the FIFO was full.

## Operation
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce counter: counts cycles in which the synchronised level differs from the accepted level, and clears whenever they match.
  - The accepted level flips when the counter reaches DEBOUNCE_CYCLES.
  - A 0→1 flip of the accepted level produces a one-cycle press pulse. Releases produce nothing.
- FSM states and transitions, on the startStop press pulse:
  - IDLE→RUN.
  - RUN→PAUSE.
  - PAUSE→RUN.
  - There is no path back to IDLE except resetButton.
- Counter:
  - Prescaler counts 0..TICK_DIV-1 only in RUN and holds its value in PAUSE.
  - On prescaler terminal, count increments.
  - Wrap/saturate follows SATURATE; wrapped is set in the cycle the event occurs.
  - count is held at 0 in IDLE.
- Lap:
  - A lap press in RUN pushes the current count register value (pre-increment if a tick coincides).
  - A lap press in IDLE or PAUSE is ignored.
- FIFO:
  - A push when full and not popping is dropped and sets lapOverflow.
  - Push and pop in the same cycle while full both take effect; nothing is dropped.
  - Pop when empty does nothing.
- Simultaneous startStop and lap presses in RUN: the lap is captured, then the FSM enters PAUSE.

## Timing
- Reset values (async, immediate): state IDLE, reset=1, cnt=0, count=0, wrapped=0, lapValid=0, lapData=0, lapFull=0, lapOverflow=0. Synchronisers, debouncers and the prescaler are 0.
- Press latency: a button held high from before clock edge k is sampled by the first flop at edge k. The press pulse is high during the cycle after edge k+1+DEBOUNCE_CYCLES. A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- State change is visible in the cycle after the press-pulse cycle; reset and cnt are Moore outputs.
- First increment: TICK_DIV cycles after cnt rises.
- Lap push: lapValid rises in the cycle after the lap press-pulse cycle. lapData is registered head, FWFT.
- Pop: the head advances on the edge where lapValid && lapReady.
- resetButton asserted mid-count or mid-debounce: everything clears asynchronously, and the FIFO contents are discarded.

## Structure
- Shared package lap_stopwatch_pkg holds:
  - State encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - Parameter range checks.
- Sub-module button_conditioner (parameter DEBOUNCE_CYCLES; ports clk, resetButton, rawIn, press), instantiated twice.
- FIFO, counter and FSM stay in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TICK_DIV=2, COUNT_WIDTH=4, LAP_DEPTH=2.
- Reset, then startStop held 10 cycles -> press pulse 6 cycles after first sampling; cnt=1 and reset=0 the cycle after the pulse; count reaches 3 after 6 further cycles.
- startStop glitch of 3 cycles in RUN -> no pulse, stays RUN; press/release/press -> RUN→PAUSE→RUN with count frozen during PAUSE and the prescaler phase preserved.
- SATURATE=0, run 32 cycles -> count wraps 15→0 and wrapped=1; SATURATE=1 -> count holds at 15 and wrapped=1.
- Three lap presses in RUN with lapReady=0 -> two entries held, lapFull=1, third dropped, lapOverflow=1; lapReady=1 -> lapData pops the first then the second value, then lapValid=0.
- FIFO full, lap push coincident with pop -> lapFull stays 1, no overflow, new value becomes the tail.
- Lap and startStop pressed together in RUN -> the lap entry equals count in the pulse cycle, then PAUSE; resetButton mid-RUN -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/lap_stopwatch_pkg.sv
// Shared definitions for the lap stopwatch controller.
//   state_t    : controller FSM encoding (IDLE/RUN/PAUSE)
//   params_ok  : parameter range check used at elaboration
//   width_for  : bits needed to hold 0..max_value (minimum 1)
package lap_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  function automatic bit params_ok(input int unsigned debounce_cycles,
                                   input int unsigned tick_div,
                                   input int unsigned count_width,
                                   input int unsigned lap_depth);
    return (debounce_cycles >= 2) && (tick_div >= 1) && (count_width >= 1) &&
           (lap_depth >= 2) && ((lap_depth & (lap_depth - 1)) == 0);
  endfunction

  function automatic int unsigned width_for(input int unsigned max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/lap_stopwatch_controller_button_conditioner.sv
// Raw push-button conditioner: 2-flop synchroniser, debounce counter and
// rising-edge press detector.
//   clk         : system clock
//   resetButton : asynchronous active-high reset
//   rawIn       : raw asynchronous button level
//   press       : one-cycle pulse when the accepted level rises 0->1
module button_conditioner
  import lap_stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic resetButton,
  input  logic rawIn,
  output logic press
);

  localparam int unsigned DW = width_for(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [DW-1:0] r_db;

  // The counter holds the number of mismatching cycles already seen; the
  // flip happens on the DEBOUNCE_CYCLES-th mismatching cycle, so the
  // terminal compare is against DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or posedge resetButton) begin
    if (resetButton) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_db    <= '0;
    end else begin
      r_sync1 <= rawIn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_db <= '0;
      end else if (r_db == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_db    <= '0;
        r_press <= r_sync2;
      end else begin
        r_db <= r_db + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/lap_stopwatch_controller.sv
// Lap stopwatch controller: debounced start/stop and lap buttons, IDLE/RUN/
// PAUSE FSM, prescaled elapsed counter (wrap or saturate) and a FWFT lap FIFO
// drained with a valid/ready handshake.
//   clk, resetButton          : clock, asynchronous active-high reset
//   startStopButton, lapButton: raw buttons
//   reset, cnt                : Moore outputs (IDLE, RUN)
//   count, wrapped            : elapsed count and sticky wrap/saturate flag
//   lapData/lapValid/lapReady : FIFO head and handshake
//   lapFull, lapOverflow      : FIFO full and sticky dropped-lap flag
module lap_stopwatch_controller
  import lap_stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 1,
  parameter int unsigned COUNT_WIDTH     = 16,
  parameter int unsigned SATURATE        = 0,
  parameter int unsigned LAP_DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   resetButton,
  input  logic                   startStopButton,
  input  logic                   lapButton,
  output logic                   reset,
  output logic                   cnt,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   wrapped,
  output logic [COUNT_WIDTH-1:0] lapData,
  output logic                   lapValid,
  input  logic                   lapReady,
  output logic                   lapFull,
  output logic                   lapOverflow
);

  localparam int unsigned PW = width_for(TICK_DIV - 1);
  localparam int unsigned AW = $clog2(LAP_DEPTH);

  if (!params_ok(DEBOUNCE_CYCLES, TICK_DIV, COUNT_WIDTH, LAP_DEPTH)) begin : g_param_check
    $error("lap_stopwatch_controller: parameter out of range");
  end

  logic w_ss_press;
  logic w_lap_press;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_btn (
    .clk         (clk),
    .resetButton (resetButton),
    .rawIn       (startStopButton),
    .press       (w_ss_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_btn (
    .clk         (clk),
    .resetButton (resetButton),
    .rawIn       (lapButton),
    .press       (w_lap_press)
  );

  // FSM
  state_t r_state;
  state_t w_next;
  logic   w_reset;
  logic   w_cnt;

  always_ff @(posedge clk or posedge resetButton) begin
    if (resetButton) r_state <= IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_reset = 1'b0;
    w_cnt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_reset = 1'b1;
        if (w_ss_press) w_next = RUN;
      end
      RUN: begin
        w_cnt = 1'b1;
        if (w_ss_press) w_next = PAUSE;
      end
      PAUSE: begin
        if (w_ss_press) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  assign reset = w_reset;
  assign cnt   = w_cnt;

  // Prescaler and elapsed counter
  logic [PW-1:0]          r_presc;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_count_inc;
  logic                   r_wrapped;
  logic                   w_tick;

  assign w_count_inc = r_count + 1'b1;
  assign w_tick      = (r_state == RUN) && (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge resetButton) begin
    if (resetButton) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (r_state == IDLE) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (r_state == RUN) begin
      if (w_tick) begin
        r_presc <= '0;
        if (SATURATE != 0) begin
          if (r_count != '1) begin
            r_count <= w_count_inc;
            if (w_count_inc == '1) r_wrapped <= 1'b1;
          end
        end else begin
          r_count <= w_count_inc;
          if (r_count == '1) r_wrapped <= 1'b1;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign count   = r_count;
  assign wrapped = r_wrapped;

  // Lap FIFO; pointers carry one extra bit to separate full from empty.
  logic [COUNT_WIDTH-1:0] r_mem [LAP_DEPTH];
  logic [AW:0]            r_wr;
  logic [AW:0]            r_rd;
  logic                   r_ovf;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push_req;
  logic                   w_push;

  assign w_empty    = (r_wr == r_rd);
  assign w_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop      = !w_empty && lapReady;
  assign w_push_req = w_lap_press && (r_state == RUN);
  // When full, a simultaneous pop frees the slot being written (same index).
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk or posedge resetButton) begin
    if (resetButton) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push_req && !w_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= r_count;
  end

  assign lapData     = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
  assign lapValid    = !w_empty;
  assign lapFull     = w_full;
  assign lapOverflow = r_ovf;

endmodule

// File: tb/tb_lap_stopwatch_controller.sv
module tb_lap_stopwatch_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ss  = 1'b0;
  logic       lap = 1'b0;
  logic       rdy = 1'b0;

  logic       reset0, cnt0, wrap0, valid0, full0, ovf0;
  logic [3:0] count0, data0;
  logic       reset1, cnt1, wrap1, valid1, full1, ovf1;
  logic [3:0] count1, data1;

  always #5 clk = ~clk;

  lap_stopwatch_controller #(
    .DEBOUNCE_CYCLES(4), .TICK_DIV(2), .COUNT_WIDTH(4), .SATURATE(0), .LAP_DEPTH(2)
  ) u_dut_wrap (
    .clk(clk), .resetButton(rst), .startStopButton(ss), .lapButton(lap),
    .reset(reset0), .cnt(cnt0), .count(count0), .wrapped(wrap0),
    .lapData(data0), .lapValid(valid0), .lapReady(rdy), .lapFull(full0),
    .lapOverflow(ovf0)
  );

  lap_stopwatch_controller #(
    .DEBOUNCE_CYCLES(4), .TICK_DIV(2), .COUNT_WIDTH(4), .SATURATE(1), .LAP_DEPTH(2)
  ) u_dut_sat (
    .clk(clk), .resetButton(rst), .startStopButton(ss), .lapButton(lap),
    .reset(reset1), .cnt(cnt1), .count(count1), .wrapped(wrap1),
    .lapData(data1), .lapValid(valid1), .lapReady(rdy), .lapFull(full1),
    .lapOverflow(ovf1)
  );

  // Inputs held for n clock edges, then outputs compared.
  typedef struct {
    int ss, lap, rdy, n;
    int e_reset, e_cnt, e_count, e_valid, e_data, e_full, e_ovf, e_wrap;
    int e_count_s, e_wrap_s;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic step_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //                   ss lap rdy n  rst cnt count v data f ovf wrap cnt_s wrap_s
    vecs.push_back(vec_t'{1, 0, 0, 6,  1,  0,  0,   0, 0,  0, 0,  0,   0,  0});
    vecs.push_back(vec_t'{1, 0, 0, 1,  0,  1,  0,   0, 0,  0, 0,  0,   0,  0});
    vecs.push_back(vec_t'{1, 0, 0, 3,  0,  1,  1,   0, 0,  0, 0,  0,   1,  0});
    vecs.push_back(vec_t'{0, 0, 0, 3,  0,  1,  3,   0, 0,  0, 0,  0,   3,  0});
    vecs.push_back(vec_t'{0, 0, 0, 6,  0,  1,  6,   0, 0,  0, 0,  0,   6,  0});
    vecs.push_back(vec_t'{1, 0, 0, 3,  0,  1,  7,   0, 0,  0, 0,  0,   7,  0});
    vecs.push_back(vec_t'{0, 0, 0, 5,  0,  1, 10,   0, 0,  0, 0,  0,  10,  0});
    vecs.push_back(vec_t'{1, 0, 0, 6,  0,  1, 13,   0, 0,  0, 0,  0,  13,  0});
    vecs.push_back(vec_t'{1, 0, 0, 1,  0,  0, 13,   0, 0,  0, 0,  0,  13,  0});
    vecs.push_back(vec_t'{0, 0, 0,10,  0,  0, 13,   0, 0,  0, 0,  0,  13,  0});
    vecs.push_back(vec_t'{1, 0, 0, 6,  0,  0, 13,   0, 0,  0, 0,  0,  13,  0});
    vecs.push_back(vec_t'{1, 0, 0, 1,  0,  1, 13,   0, 0,  0, 0,  0,  13,  0});
    vecs.push_back(vec_t'{1, 0, 0, 1,  0,  1, 14,   0, 0,  0, 0,  0,  14,  0});
    vecs.push_back(vec_t'{0, 0, 0, 2,  0,  1, 15,   0, 0,  0, 0,  0,  15,  1});
    vecs.push_back(vec_t'{0, 0, 0, 2,  0,  1,  0,   0, 0,  0, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 0, 0, 4,  0,  1,  2,   0, 0,  0, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 1, 0, 6,  0,  1,  5,   0, 0,  0, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 1, 0, 1,  0,  1,  5,   1, 5,  0, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 0, 0, 6,  0,  1,  8,   1, 5,  0, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 1, 0, 6,  0,  1, 11,   1, 5,  0, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 1, 0, 1,  0,  1, 12,   1, 5,  1, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 0, 0, 6,  0,  1, 15,   1, 5,  1, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 1, 0, 6,  0,  1,  2,   1, 5,  1, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 1, 1, 1,  0,  1,  2,   1,11,  1, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 0, 0, 6,  0,  1,  5,   1,11,  1, 0,  1,  15,  1});
    vecs.push_back(vec_t'{0, 1, 0, 7,  0,  1,  9,   1,11,  1, 1,  1,  15,  1});
    vecs.push_back(vec_t'{0, 0, 1, 1,  0,  1,  9,   1, 2,  0, 1,  1,  15,  1});
    vecs.push_back(vec_t'{0, 0, 1, 1,  0,  1, 10,   0, 0,  0, 1,  1,  15,  1});
    vecs.push_back(vec_t'{0, 0, 1, 2,  0,  1, 11,   0, 0,  0, 1,  1,  15,  1});
    vecs.push_back(vec_t'{0, 0, 0, 2,  0,  1, 12,   0, 0,  0, 1,  1,  15,  1});
    vecs.push_back(vec_t'{1, 1, 0, 6,  0,  1, 15,   0, 0,  0, 1,  1,  15,  1});
    vecs.push_back(vec_t'{1, 1, 0, 1,  0,  0, 15,   1,15,  0, 1,  1,  15,  1});
    vecs.push_back(vec_t'{0, 0, 0, 6,  0,  0, 15,   1,15,  0, 1,  1,  15,  1});
    vecs.push_back(vec_t'{1, 0, 0, 7,  0,  1, 15,   1,15,  0, 1,  1,  15,  1});

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_reset",   -1, int'(reset0), 1);
    chk("rst_cnt",     -1, int'(cnt0),   0);
    chk("rst_count",   -1, int'(count0), 0);
    chk("rst_wrapped", -1, int'(wrap0),  0);
    chk("rst_valid",   -1, int'(valid0), 0);
    chk("rst_data",    -1, int'(data0),  0);
    chk("rst_full",    -1, int'(full0),  0);
    chk("rst_ovf",     -1, int'(ovf0),   0);
    chk("rst_count_s", -1, int'(count1), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      ss  = (vecs[i].ss  != 0);
      lap = (vecs[i].lap != 0);
      rdy = (vecs[i].rdy != 0);
      step_edges(vecs[i].n);
      chk("reset",     i, int'(reset0), vecs[i].e_reset);
      chk("cnt",       i, int'(cnt0),   vecs[i].e_cnt);
      chk("count",     i, int'(count0), vecs[i].e_count);
      chk("lapValid",  i, int'(valid0), vecs[i].e_valid);
      chk("lapData",   i, int'(data0),  vecs[i].e_data);
      chk("lapFull",   i, int'(full0),  vecs[i].e_full);
      chk("lapOvf",    i, int'(ovf0),   vecs[i].e_ovf);
      chk("wrapped",   i, int'(wrap0),  vecs[i].e_wrap);
      chk("count_sat", i, int'(count1), vecs[i].e_count_s);
      chk("wrap_sat",  i, int'(wrap1),  vecs[i].e_wrap_s);
    end

    // Run on past the wrap, then reset asynchronously mid-cycle.
    step_edges(3);
    chk("pre_reset_cnt",   100, int'(cnt0),   1);
    chk("pre_reset_count", 100, int'(count0), 1);
    ss = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("mid_reset",     101, int'(reset0), 1);
    chk("mid_cnt",       101, int'(cnt0),   0);
    chk("mid_count",     101, int'(count0), 0);
    chk("mid_wrapped",   101, int'(wrap0),  0);
    chk("mid_valid",     101, int'(valid0), 0);
    chk("mid_data",      101, int'(data0),  0);
    chk("mid_full",      101, int'(full0),  0);
    chk("mid_ovf",       101, int'(ovf0),   0);
    chk("mid_count_s",   101, int'(count1), 0);
    chk("mid_wrapped_s", 101, int'(wrap1),  0);
    @(posedge clk);
    #1 rst = 1'b0;
    step_edges(8);
    chk("post_reset",   102, int'(reset0), 1);
    chk("post_valid",   102, int'(valid0), 0);
    chk("post_count",   102, int'(count0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
